score_scan_ctrl: RTL and testbench
==================================

SCORE_SCAN_CTRL -- requirements
Module: score_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clock cycles per digit slot (minimum 4).
REQ-002 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port add_valid  input  1  add request present.
REQ-005 SHALL have port add_val  input  8  two-digit packed BCD points value, [7:4] tens and [3:0] units.
REQ-006 SHALL have port add_ready  output  1  ready to accept an add.
REQ-007 SHALL have port clear  input  1  synchronous score clear.
REQ-008 SHALL have port score  output  16  packed BCD score, [15:12] thousands down to [3:0] units.
REQ-009 SHALL have port sat  output  1  score saturated at 9999.
REQ-010 SHALL have port an  output  4  digit enables, active-low; an[0] is units and an[3] is thousands.
REQ-011 SHALL have port dig_a, dig_b, dig_c, dig_d  output  1 each  selected nibble for the shared hex-to-segment decoder; dig_a is MSB and dig_d is LSB.

Function
REQ-012 SHALL accept an add on a rising edge where add_valid and add_ready are both 1.
REQ-013 SHALL drive add_ready as 1 only when the add FSM is in IDLE and clear is 0; add_ready is combinational on clear.
REQ-014 SHALL implement the add FSM with states IDLE, ADD0, ADD1, ADD2 and ADD3.
REQ-015 SHALL move IDLE->ADD0 on accept, then ADD0->ADD1->ADD2->ADD3->IDLE on consecutive cycles.
REQ-016 SHALL, as a result of REQ-015, allow the next accept no earlier than 5 cycles after the previous one.
REQ-017 SHALL capture add_val at accept and hold it; later changes to add_val do not affect the add in progress.
REQ-018 SHALL, in state ADDn, add BCD digit n plus the carry from the previous state. The addend is the captured units digit in ADD0, the tens digit in ADD1, and 0 in ADD2 and ADD3.
REQ-019 SHALL compute each digit result as the digit sum; when the sum is >9, the digit becomes sum-10 and carry becomes 1.
REQ-020 SHALL clamp any captured add_val nibble greater than 9 to 9 before adding.
REQ-021 SHALL, on a carry out of ADD3, set score to 16'h9999 and set sat to 1.
REQ-022 SHALL, once sat is 1, keep score at 9999; further accepted adds still run the full FSM but leave score unchanged.
REQ-023 SHALL, when clear is 1 at a rising edge, set score to 0 and sat to 0 and force the FSM to IDLE. This aborts any add in progress, and clear has priority over every other event.
REQ-024 SHALL drive the score output from the working register, so intermediate values are visible during ADD0 to ADD3.
REQ-025 SHALL maintain a display shadow register that loads score only at the first cycle of the digit-0 slot and only if the FSM is in IDLE; otherwise the shadow keeps its previous value.
REQ-026 SHALL run a scan prescaler counting 0 to SCAN_DIV-1 and a 2-bit slot counter that advances 0->1->2->3->0 when the prescaler wraps.
REQ-027 SHALL make the first prescaler cycle of every slot dead time, with an=4'b1111.
REQ-028 SHALL, for the remaining SCAN_DIV-1 cycles of a slot, drive an[slot]=0 and all other an bits 1.
REQ-029 SHALL drive dig_a..dig_d from shadow digit[slot] for the whole slot, including the dead-time cycle.
REQ-030 SHALL blank leading zeros: a slot for digit k in 1..3 keeps an all 1 when shadow digits k..3 are all zero. Digit 0 is never blanked.
REQ-031 SHALL keep the scan independent of add and clear activity; the scan never stalls.

Reset
REQ-032 SHALL, while rst=1, set score=0, sat=0, FSM=IDLE, add_ready=0, shadow=0, prescaler=0, slot=0, an=4'b1111 and dig_a..dig_d=0.
REQ-033 SHALL, on the first rising edge after rst is released, set add_ready to 1.
REQ-034 SHALL, on a reset asserted mid-add, discard the add immediately and never apply a partial result.

Verification
REQ-035 SHALL cover: reset, then add_val=8'h20 accepted at cycle T -> add_ready=0 over T+1..T+4, score=16'h0020 by T+5, add_ready=1 at T+5.
REQ-036 SHALL cover: score=0995 plus add_val=8'h05 -> score=16'h1000 with carry propagated through all digits, sat=0.
REQ-037 SHALL cover: score=9990 plus add_val=8'h50 -> score=16'h9999, sat=1; a further add of 8'h01 leaves 9999; clear -> score=0, sat=0.
REQ-038 SHALL cover: clear asserted during ADD1 with add_valid=1 -> next cycle score=0 and FSM=IDLE; add_ready=0 during the clear cycle and no add is accepted.
REQ-039 SHALL cover: SCAN_DIV=4, shadow=0042 -> an sequence per 4-cycle slot is 1111,1110,1110,1110 then 1111,1101,1101,1101; slots 2 and 3 stay 1111; dig equals 2 then 4.
REQ-040 SHALL cover: add_val=8'hAF -> treated as 99, so score 0000 -> 0099; rst pulsed during ADD2 -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/score_scan_ctrl.sv
// score_scan_ctrl: BCD score accumulator with multi-cycle digit-serial add and a multiplexed 4-digit display scan.
module score_scan_ctrl #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        add_valid,
  input  logic [7:0]  add_val,
  output logic        add_ready,
  input  logic        clear,
  output logic [15:0] score,
  output logic        sat,
  output logic [3:0]  an,
  output logic        dig_a,
  output logic        dig_b,
  output logic        dig_c,
  output logic        dig_d
);
  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  typedef enum logic [2:0] {ADD0 = 3'd0, ADD1 = 3'd1, ADD2 = 3'd2, ADD3 = 3'd3, IDLE = 3'd4} state_t;
  state_t          state_q, state_d;
  logic [15:0]     score_q, score_d, shadow_q, shadow_d;
  logic [7:0]      val_q, val_d;
  logic            carry_q, carry_d, sat_q, sat_d, rdy_q;
  logic [PW-1:0]   presc_q, presc_d;
  logic [1:0]      slot_q, slot_d, idx;
  logic [3:0]      dsel, addend;
  logic [4:0]      sum, sum_adj;
  logic            accept, wrap, blank;
  // ADDn states share one digit adder; the low state bits select the digit
  always_comb begin
    add_ready = rdy_q && state_q == IDLE && !clear;
    accept    = add_valid && add_ready;
    idx       = state_q[1:0];
    dsel      = score_q[{idx, 2'b00} +: 4];
    addend    = idx == 2'd0 ? val_q[3:0] : idx == 2'd1 ? val_q[7:4] : 4'd0;
    sum       = {1'b0, dsel} + {1'b0, addend} + {4'd0, carry_q};
    sum_adj   = sum - 5'd10;
    state_d   = state_q;
    score_d   = score_q;
    sat_d     = sat_q;
    val_d     = val_q;
    carry_d   = carry_q;
    if (clear) begin
      state_d = IDLE;
      score_d = 16'h0000;
      sat_d   = 1'b0;
      carry_d = 1'b0;
    end else if (state_q == IDLE) begin
      if (accept) begin
        state_d = ADD0;
        val_d   = {add_val[7:4] > 4'd9 ? 4'd9 : add_val[7:4], add_val[3:0] > 4'd9 ? 4'd9 : add_val[3:0]};
        carry_d = 1'b0;
      end
    end else begin
      state_d = state_q == ADD3 ? IDLE : state_t'(state_q + 3'd1);
      carry_d = sum > 5'd9;
      if (!sat_q) begin
        if (state_q == ADD3 && sum > 5'd9) begin
          score_d = 16'h9999;
          sat_d   = 1'b1;
        end else begin
          score_d[{idx, 2'b00} +: 4] = sum > 5'd9 ? sum_adj[3:0] : sum[3:0];
        end
      end
    end
  end
  // Shadow refreshes on entry to the units slot so a whole scan frame shows one settled score
  always_comb begin
    wrap     = presc_q == PW'(SCAN_DIV - 1);
    presc_d  = wrap ? '0 : presc_q + 1'b1;
    slot_d   = wrap ? slot_q + 2'd1 : slot_q;
    shadow_d = (wrap && slot_q == 2'd3 && state_q == IDLE) ? score_q : shadow_q;
    blank    = slot_q == 2'd1 ? shadow_q[15:4] == 12'd0 :
               slot_q == 2'd2 ? shadow_q[15:8] == 8'd0 :
               slot_q == 2'd3 ? shadow_q[15:12] == 4'd0 : 1'b0;
    an       = (presc_q == '0 || blank) ? 4'hF : ~(4'b0001 << slot_q);
    {dig_a, dig_b, dig_c, dig_d} = shadow_q[{slot_q, 2'b00} +: 4];
    score    = score_q;
    sat      = sat_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      score_q  <= '0;
      sat_q    <= 1'b0;
      val_q    <= '0;
      carry_q  <= 1'b0;
      rdy_q    <= 1'b0;
      shadow_q <= '0;
      presc_q  <= '0;
      slot_q   <= '0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      sat_q    <= sat_d;
      val_q    <= val_d;
      carry_q  <= carry_d;
      rdy_q    <= 1'b1;
      shadow_q <= shadow_d;
      presc_q  <= presc_d;
      slot_q   <= slot_d;
    end
  end
endmodule

// File: tb/tb_score_scan_ctrl.sv
// tb_score_scan_ctrl: randomized and directed checks of score_scan_ctrl against a decimal-arithmetic reference model.
module tb_score_scan_ctrl;
  logic        clk = 1'b0, rst = 1'b1, add_valid = 1'b0, clear = 1'b0;
  logic [7:0]  add_val = 8'h00;
  logic        add_ready, sat, dig_a, dig_b, dig_c, dig_d;
  logic [15:0] score;
  logic [3:0]  an;
  int n_cmp = 0, n_err = 0;
  int m_score = 0, m_sat = 0, m_busy = 0, m_pend = 0, m_shadow = 0, m_cyc = 0, m_rdy = 0;

  score_scan_ctrl #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .add_valid(add_valid), .add_val(add_val), .add_ready(add_ready),
    .clear(clear), .score(score), .sat(sat), .an(an),
    .dig_a(dig_a), .dig_b(dig_b), .dig_c(dig_c), .dig_d(dig_d)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int clampv(input logic [7:0] v);
    int t, u;
    t = v[7:4] > 9 ? 9 : int'(v[7:4]);
    u = v[3:0] > 9 ? 9 : int'(v[3:0]);
    return t * 10 + u;
  endfunction

  function automatic int pow10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r *= 10;
    return r;
  endfunction

  task automatic check_all();
    int p, s, exp_an;
    bit blank;
    p = m_cyc % 4;
    s = (m_cyc / 4) % 4;
    blank = s > 0 && m_shadow < pow10(s);
    exp_an = (p == 0 || blank) ? 15 : (15 & ~(1 << s));
    chk("add_ready", 32'(add_ready), 32'(m_rdy != 0 && m_busy == 0 && !clear));
    if (m_busy == 0) begin
      chk("score", 32'(score), 32'(to_bcd(m_score)));
      chk("sat", 32'(sat), 32'(m_sat));
    end
    chk("an", 32'(an), 32'(exp_an));
    chk("dig", 32'({dig_a, dig_b, dig_c, dig_d}), 32'((m_shadow / pow10(s)) % 10));
  endtask

  task automatic model_reset();
    m_score = 0; m_sat = 0; m_busy = 0; m_shadow = 0; m_cyc = 0; m_rdy = 0;
  endtask

  task automatic step(input logic v, input logic [7:0] val, input logic c);
    bit ready;
    add_valid = v; add_val = val; clear = c;
    @(posedge clk);
    ready = m_rdy != 0 && m_busy == 0 && !c;
    if (m_cyc % 4 == 3 && (m_cyc / 4) % 4 == 3 && m_busy == 0) m_shadow = m_score;
    if (c) begin
      m_score = 0; m_sat = 0; m_busy = 0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0 && m_sat == 0) begin
        if (m_score + m_pend > 9999) begin
          m_score = 9999; m_sat = 1;
        end else m_score += m_pend;
      end
    end else if (ready && v) begin
      m_busy = 4; m_pend = clampv(val);
    end
    m_rdy = 1;
    m_cyc++;
    #1 check_all();
  endtask

  task automatic accept(input logic [7:0] val);
    int k = 0;
    do begin
      step(1'b1, val, 1'b0);
      k++;
    end while (m_busy != 4 && k < 20);
    if (m_busy != 4) chk("accept_timeout", 32'(m_busy), 32'd4);
  endtask

  task automatic add(input logic [7:0] val);
    accept(val);
    repeat (4) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    #3 check_all();
    @(negedge clk) rst = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    chk("ready_after_rst", 32'(add_ready), 32'd1);
    add(8'h20);
    chk("add20", 32'(score), 32'h0020);
    chk("ready_t5", 32'(add_ready), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    repeat (10) add(8'h99);
    add(8'h05);
    chk("s0995", 32'(score), 32'h0995);
    add(8'h05);
    chk("carry1000", 32'(score), 32'h1000);
    chk("sat1000", 32'(sat), 32'd0);
    step(1'b0, 8'h00, 1'b1);
    repeat (100) add(8'h99);
    add(8'h90);
    chk("s9990", 32'(score), 32'h9990);
    add(8'h50);
    chk("sat9999", 32'(score), 32'h9999);
    chk("sat_flag", 32'(sat), 32'd1);
    add(8'h01);
    chk("hold9999", 32'(score), 32'h9999);
    step(1'b0, 8'h00, 1'b1);
    chk("clr_score", 32'(score), 32'h0000);
    chk("clr_sat", 32'(sat), 32'd0);
    accept(8'h33);
    step(1'b1, 8'h33, 1'b0);
    add_valid = 1'b1; clear = 1'b1;
    #1 chk("rdy_in_clear", 32'(add_ready), 32'd0);
    step(1'b1, 8'h33, 1'b1);
    chk("abort_score", 32'(score), 32'h0000);
    repeat (5) step(1'b0, 8'h00, 1'b0);
    chk("no_add_after_clr", 32'(score), 32'h0000);
    add(8'h42);
    repeat (20) step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    add(8'hAF);
    chk("clamp99", 32'(score), 32'h0099);
    accept(8'h11);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    #2 rst = 1'b1;
    model_reset();
    #1 check_all();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (3) step(1'b0, 8'h00, 1'b0);
    chk("post_rst_score", 32'(score), 32'h0000);
    repeat (600) step(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 40) == 0);
    repeat (50) add(8'h99);
    repeat (300) step(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 60) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
